// File: rtl/rl11_dma_pkg.sv
// Shared definitions for the RL11 Unibus DMA engine: FSM states, ARM register map,
// Unibus cycle codes and the identification word.
package rl11_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_SETUP,
    ST_MSYN,
    ST_END,
    ST_RELEASE
  } state_t;

  localparam logic [2:0] REG_ID   = 3'd0;
  localparam logic [2:0] REG_CSR  = 3'd1;
  localparam logic [2:0] REG_ADDR = 3'd2;
  localparam logic [2:0] REG_STAT = 3'd3;

  localparam logic [1:0] C_DATI = 2'b00;
  localparam logic [1:0] C_DATO = 2'b10;

  localparam logic [31:0] RL_ID      = 32'h52442002;
  localparam logic [31:0] RD_INVALID = 32'hDEADBEEF;

endpackage

// File: rtl/rl11_dma_if.sv
// Unibus signal bundle seen by the DMA engine (master) and by the bus/slave side.
interface rl11_dma_if;

  logic        npg_in_h;
  logic        bbsy_in_h;
  logic        ssyn_in_h;
  logic        init_in_h;
  logic [15:0] d_in_h;

  logic        npr_out_h;
  logic        sack_out_h;
  logic        bbsy_out_h;
  logic        msyn_out_h;
  logic [17:0] a_out_h;
  logic [1:0]  c_out_h;
  logic [15:0] d_out_h;

  modport master (
    input  npg_in_h, bbsy_in_h, ssyn_in_h, init_in_h, d_in_h,
    output npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, a_out_h, c_out_h, d_out_h
  );

  modport slave (
    output npg_in_h, bbsy_in_h, ssyn_in_h, init_in_h, d_in_h,
    input  npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, a_out_h, c_out_h, d_out_h
  );

endinterface

// File: rtl/rl11_dma_timer.sv
// Loadable down-counter shared by the address deskew and SSYN timeout waits.
// expired is high whenever the count has reached zero.
module rl11_dma_timer #(
  parameter int W = 16
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLOCK) begin
    if (RESET)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/rl11_dma.sv
// RL11 Unibus NPR DMA engine: moves words between the local buffer RAM and Unibus
// memory one bus tenure per word, programmed through a small ARM register port.
module rl11_dma
  import rl11_dma_pkg::*;
#(
  parameter int DESKEW  = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armraddr,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  output logic [15:0] buf_addr,
  output logic [15:0] buf_wdata,
  output logic        buf_we,
  input  logic [15:0] buf_rdata,
  rl11_dma_if.master  bus
);

  localparam int TMAX = (DESKEW > TIMEOUT) ? DESKEW : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  state_t        state, state_nx;
  logic          busy, done, nxm, timeout_seen, abort, dir;
  logic [17:0]   addr;
  logic [15:0]   wordcount, bufidx;
  logic          tmr_load, tmr_expired;
  logic [TW-1:0] tmr_val;

  logic csr_wr, addr_wr, start_go, abort_now, bus_free, nxm_hit, finish;
  logic unused_bits;

  assign csr_wr    = armwrite && (armwaddr == REG_CSR);
  assign addr_wr   = armwrite && (armwaddr == REG_ADDR);
  assign start_go  = csr_wr && !busy && armwdata[0] && (armwdata[31:16] != 16'h0);
  // A same-cycle abort write counts immediately so it beats a concurrent grant.
  assign abort_now = abort || (csr_wr && busy && armwdata[3]);
  assign bus_free  = !bus.npg_in_h && !bus.bbsy_in_h && !bus.ssyn_in_h;
  assign nxm_hit   = (state == ST_MSYN) && !bus.ssyn_in_h && tmr_expired;
  assign finish    = nxm || abort_now || (wordcount == 16'd1);
  assign unused_bits = ^{armwdata[15:4], armwdata[1]};

  assign buf_addr  = bufidx;
  assign buf_wdata = bus.d_in_h;

  rl11_dma_timer #(.W(TW)) u_timer (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (bus.init_in_h) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start_go) state_nx = ST_REQ;
        ST_REQ: begin
          if (abort_now)         state_nx = ST_IDLE;
          else if (bus.npg_in_h) state_nx = ST_GRANT;
        end
        ST_GRANT: begin
          if (bus_free) begin
            state_nx = ST_SETUP;
            tmr_load = 1'b1;
            tmr_val  = TW'(DESKEW - 1);
          end
        end
        ST_SETUP: begin
          if (tmr_expired) begin
            state_nx = ST_MSYN;
            tmr_load = 1'b1;
            tmr_val  = TW'(TIMEOUT - 1);
          end
        end
        ST_MSYN:    if (bus.ssyn_in_h || tmr_expired) state_nx = ST_END;
        ST_END:     if (!bus.ssyn_in_h) state_nx = ST_RELEASE;
        ST_RELEASE: state_nx = finish ? ST_IDLE : ST_REQ;
        default:    state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.npr_out_h  = 1'b0;
    bus.sack_out_h = 1'b0;
    bus.bbsy_out_h = 1'b0;
    bus.msyn_out_h = 1'b0;
    bus.a_out_h    = '0;
    bus.c_out_h    = '0;
    bus.d_out_h    = '0;
    buf_we         = 1'b0;
    case (state)
      ST_REQ:   bus.npr_out_h  = 1'b1;
      ST_GRANT: bus.sack_out_h = 1'b1;
      ST_SETUP, ST_MSYN, ST_END: begin
        bus.bbsy_out_h = 1'b1;
        bus.a_out_h    = addr;
        bus.c_out_h    = dir ? C_DATI : C_DATO;
        bus.d_out_h    = dir ? 16'h0 : buf_rdata;
        if (state == ST_MSYN) begin
          bus.msyn_out_h = 1'b1;
          buf_we         = dir && bus.ssyn_in_h;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      nxm          <= 1'b0;
      timeout_seen <= 1'b0;
      abort        <= 1'b0;
      dir          <= 1'b0;
      addr         <= '0;
      wordcount    <= '0;
      bufidx       <= '0;
    end else if (bus.init_in_h) begin
      busy  <= 1'b0;
      abort <= 1'b0;
      if (busy) done <= 1'b1;
    end else begin
      if (csr_wr) begin
        if (!busy) begin
          wordcount <= armwdata[31:16];
          dir       <= armwdata[2];
          done      <= 1'b0;
          nxm       <= 1'b0;
          abort     <= 1'b0;
          if (armwdata[0]) begin
            bufidx <= '0;
            if (armwdata[31:16] != 16'h0) busy <= 1'b1;
            else                          done <= 1'b1;
          end
        end else begin
          abort <= armwdata[3];
        end
      end
      if (addr_wr && !busy) addr <= {armwdata[17:1], 1'b0};
      if (nxm_hit) begin
        nxm          <= 1'b1;
        timeout_seen <= 1'b1;
      end
      if ((state == ST_REQ) && abort_now) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      // End of tenure: advance only on a completed word.
      if (state == ST_RELEASE) begin
        if (!nxm) begin
          addr      <= addr + 18'd2;
          bufidx    <= bufidx + 1'b1;
          wordcount <= wordcount - 1'b1;
        end
        if (finish) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (armraddr)
      REG_ID:   armrdata = RL_ID;
      REG_CSR:  armrdata = {wordcount, 12'h0, abort, dir, busy, done};
      REG_ADDR: armrdata = {14'h0, addr};
      REG_STAT: armrdata = {bufidx, 14'h0, nxm, timeout_seen};
      default:  armrdata = RD_INVALID;
    endcase
  end

endmodule

// File: tb/tb_rl11_dma.sv
// Bench for rl11_dma: Unibus arbiter/slave and buffer RAM models plus a
// transfer-level reference model for randomized and directed transfers.
module tb_rl11_dma;
  import rl11_dma_pkg::*;

  localparam int DESKEW  = 8;
  localparam int TIMEOUT = 1000;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        armwrite;
  logic [2:0]  armraddr, armwaddr;
  logic [31:0] armwdata, armrdata;
  logic [15:0] buf_addr, buf_wdata, buf_rdata;
  logic        buf_we;

  rl11_dma_if ubus ();

  rl11_dma #(.DESKEW(DESKEW), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .armwrite (armwrite),
    .armraddr (armraddr),
    .armwaddr (armwaddr),
    .armwdata (armwdata),
    .armrdata (armrdata),
    .buf_addr (buf_addr),
    .buf_wdata(buf_wdata),
    .buf_we   (buf_we),
    .buf_rdata(buf_rdata),
    .bus      (ubus)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_errors = 0;

  // Buffer RAM with one-cycle read latency and a backdoor load port.
  logic [15:0] bufm [0:65535];
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr, ld_data;

  always @(posedge CLOCK) begin
    if (ld_en)       bufm[ld_addr]  <= ld_data;
    else if (buf_we) bufm[buf_addr] <= buf_wdata;
    buf_rdata <= bufm[buf_addr];
  end

  // Unibus arbiter and memory slave; DATI read data is a function of address.
  bit          grant_en    = 1'b1;
  bit          slave_en    = 1'b1;
  int          slave_delay = 5;
  logic [15:0] dseed       = 16'h0;

  function automatic logic [15:0] dati_val(input logic [17:0] a);
    return a[16:1] ^ dseed;
  endfunction

  int          msyn_cnt = 0, msyn_last = 0, setup_len = 0, sack_rises = 0, log_n = 0;
  bit          post = 1'b0, sack_q = 1'b0;
  logic [17:0] log_a [0:1023];
  logic [1:0]  log_c [0:1023];
  logic [15:0] log_d [0:1023];
  int          log_s [0:1023];

  always @(negedge CLOCK) begin
    ubus.npg_in_h  = grant_en && ubus.npr_out_h;
    ubus.bbsy_in_h = 1'b0;
    if (ubus.sack_out_h && !sack_q) sack_rises++;
    sack_q = ubus.sack_out_h;
    if (ubus.msyn_out_h) begin
      msyn_cnt++;
      if (slave_en && !ubus.ssyn_in_h && msyn_cnt >= slave_delay) begin
        ubus.d_in_h    = dati_val(ubus.a_out_h);
        ubus.ssyn_in_h = 1'b1;
        if (log_n < 1024) begin
          log_a[log_n] = ubus.a_out_h;
          log_c[log_n] = ubus.c_out_h;
          log_d[log_n] = ubus.d_out_h;
          log_s[log_n] = setup_len;
        end
        log_n++;
      end
    end else begin
      if (msyn_cnt != 0) begin
        msyn_last = msyn_cnt;
        msyn_cnt  = 0;
        post      = 1'b1;
      end
      ubus.ssyn_in_h = 1'b0;
      if (!ubus.bbsy_out_h) begin
        setup_len = 0;
        post      = 1'b0;
      end else if (!post) begin
        setup_len++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic arm_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge CLOCK);
    armwrite = 1'b1;
    armwaddr = a;
    armwdata = d;
    @(negedge CLOCK);
    armwrite = 1'b0;
  endtask

  task automatic arm_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge CLOCK);
    armraddr = a;
    #1 d = armrdata;
  endtask

  task automatic buf_load(input int idx, input logic [15:0] d);
    @(negedge CLOCK);
    ld_en   = 1'b1;
    ld_addr = 16'(idx);
    ld_data = d;
    @(negedge CLOCK);
    ld_en = 1'b0;
  endtask

  task automatic bus_zero(input string tag);
    check({tag, "_ctl"}, 32'({ubus.npr_out_h, ubus.sack_out_h, ubus.bbsy_out_h, ubus.msyn_out_h}), 32'h0);
    check({tag, "_a"},   32'(ubus.a_out_h), 32'h0);
    check({tag, "_cd"},  32'({ubus.c_out_h, ubus.d_out_h}), 32'h0);
  endtask

  task automatic wait_done(input int budget);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < budget; i++) begin
      arm_read(REG_CSR, r);
      if (r[0]) break;
    end
    check("done_reached", 32'(r[0]), 32'h1);
  endtask

  task automatic wait_msyn(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLOCK);
      if (ubus.msyn_out_h) break;
    end
    check("msyn_reached", 32'(ubus.msyn_out_h), 32'h1);
  endtask

  logic [15:0] xv [0:7];
  bit          ts_model = 1'b0;

  // One complete transfer checked against the expected word sequence.
  task automatic run_xfer(input logic [17:0] A, input int N, input bit dir, input string tag);
    int          l0, s0, j;
    logic [31:0] r;
    logic [17:0] ea;
    dseed = 16'($urandom);
    if (!dir) for (int i = 0; i < N; i++) buf_load(i, xv[i]);
    l0 = log_n;
    s0 = sack_rises;
    arm_write(REG_ADDR, {14'h0, A});
    arm_write(REG_CSR, {16'(N), 12'h0, 1'b0, dir, 1'b0, 1'b1});
    wait_done(N * (DESKEW + 60) + 200);
    check({tag, "_nwords"}, 32'(log_n - l0), 32'(N));
    check({tag, "_sacks"}, 32'(sack_rises - s0), 32'(N));
    for (int i = 0; i < N; i++) begin
      ea = A + 18'(2 * i);
      j  = l0 + i;
      check({tag, "_addr"}, 32'(log_a[j]), 32'(ea));
      check({tag, "_cmd"}, 32'(log_c[j]), 32'(dir ? C_DATI : C_DATO));
      check({tag, "_deskew"}, 32'(log_s[j] >= DESKEW), 32'h1);
      if (dir) check({tag, "_bufdata"}, 32'(bufm[i]), 32'(dati_val(ea)));
      else     check({tag, "_busdata"}, 32'(log_d[j]), 32'(xv[i]));
    end
    arm_read(REG_ADDR, r);
    check({tag, "_endaddr"}, r, {14'h0, A + 18'(2 * N)});
    arm_read(REG_CSR, r);
    check({tag, "_csr"}, r, {16'h0, 12'h0, 1'b0, dir, 1'b0, 1'b1});
    arm_read(REG_STAT, r);
    check({tag, "_stat"}, r, {16'(N), 14'h0, 1'b0, ts_model});
    bus_zero({tag, "_idle"});
  endtask

  initial begin
    logic [31:0] r;
    int          s0, l0;
    logic [17:0] ra;

    RESET         = 1'b1;
    armwrite      = 1'b0;
    armraddr      = 3'd0;
    armwaddr      = 3'd0;
    armwdata      = 32'h0;
    ubus.init_in_h = 1'b0;
    repeat (3) @(negedge CLOCK);
    bus_zero("reset");
    RESET = 1'b0;
    arm_read(REG_ID, r);   check("reg_id", r, 32'h52442002);
    arm_read(REG_CSR, r);  check("reset_csr", r, 32'h0);
    arm_read(REG_ADDR, r); check("reset_addr", r, 32'h0);
    arm_read(REG_STAT, r); check("reset_stat", r, 32'h0);
    arm_read(3'd5, r);     check("reg_invalid", r, 32'hDEADBEEF);

    slave_delay = 5;
    run_xfer(18'o777000, 3, 1'b1, "dati3");

    xv[0] = 16'o1234;
    xv[1] = 16'o5670;
    run_xfer(18'o1000, 2, 1'b0, "dato2");

    xv[0] = 16'($urandom);
    xv[1] = 16'($urandom);
    run_xfer(18'o777776, 2, 1'b0, "wrap");

    // Zero word count completes without touching the bus and clears bufidx.
    s0 = sack_rises;
    arm_write(REG_CSR, 32'h0000_0001);
    arm_read(REG_CSR, r);  check("zero_csr", r, 32'h0000_0001);
    arm_read(REG_STAT, r); check("zero_stat", r, 32'h0);
    check("zero_npr", 32'(ubus.npr_out_h), 32'h0);
    check("zero_sacks", 32'(sack_rises - s0), 32'h0);

    // Non-existent memory.
    slave_en = 1'b0;
    l0 = log_n;
    arm_write(REG_ADDR, 32'(18'o4000));
    arm_write(REG_CSR, {16'd2, 12'h0, 1'b0, 1'b1, 1'b0, 1'b1});
    wait_done(TIMEOUT + 200);
    check("nxm_msyn_len", 32'(msyn_last), 32'(TIMEOUT));
    check("nxm_nwords", 32'(log_n - l0), 32'h0);
    arm_read(REG_CSR, r);  check("nxm_csr", r, {16'd2, 12'h0, 1'b0, 1'b1, 1'b0, 1'b1});
    arm_read(REG_STAT, r); check("nxm_stat", r, 32'h3);
    arm_read(REG_ADDR, r); check("nxm_addr", r, 32'(18'o4000));
    bus_zero("nxm_idle");
    ts_model = 1'b1;
    slave_en = 1'b1;

    for (int k = 0; k < 8; k++) begin
      int n;
      bit d;
      ra = 18'($urandom) & 18'h3FFFE;
      n  = $urandom_range(1, 6);
      d  = 1'($urandom);
      slave_delay = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) xv[i] = 16'($urandom);
      run_xfer(ra, n, d, "rand");
    end

    // Abort in REQ arriving together with the grant.
    slave_delay = 5;
    grant_en = 1'b0;
    s0 = sack_rises;
    arm_write(REG_ADDR, 32'(18'o2000));
    arm_write(REG_CSR, {16'd3, 12'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    repeat (3) @(negedge CLOCK);
    check("req_npr", 32'(ubus.npr_out_h), 32'h1);
    #1 grant_en = 1'b1;
    arm_write(REG_CSR, 32'h8);
    check("abort_req_npr", 32'(ubus.npr_out_h), 32'h0);
    check("abort_req_sack", 32'(ubus.sack_out_h), 32'h0);
    repeat (3) @(negedge CLOCK);
    check("abort_req_sacks", 32'(sack_rises - s0), 32'h0);
    arm_read(REG_CSR, r);
    check("abort_req_csr", r, {16'd3, 12'h0, 1'b1, 1'b0, 1'b0, 1'b1});

    // Abort during MSYN finishes the current word only.
    slave_delay = 30;
    l0 = log_n;
    arm_write(REG_ADDR, 32'(18'o3000));
    arm_write(REG_CSR, {16'd3, 12'h0, 1'b0, 1'b1, 1'b0, 1'b1});
    wait_msyn(200);
    arm_write(REG_CSR, 32'h8);
    wait_done(500);
    check("abort_msyn_nwords", 32'(log_n - l0), 32'h1);
    arm_read(REG_ADDR, r); check("abort_msyn_addr", r, 32'(18'o3002));
    arm_read(REG_CSR, r);  check("abort_msyn_csr", r, {16'd2, 12'h0, 1'b1, 1'b1, 1'b0, 1'b1});
    arm_read(REG_STAT, r); check("abort_msyn_stat", r, {16'd1, 14'h0, 1'b0, ts_model});

    // RESET in the middle of a bus cycle.
    arm_write(REG_ADDR, 32'(18'o5000));
    arm_write(REG_CSR, {16'd4, 12'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    wait_msyn(200);
    RESET = 1'b1;
    @(negedge CLOCK);
    bus_zero("rst_mid");
    arm_read(REG_CSR, r); check("rst_mid_csr", r, 32'h0);
    RESET = 1'b0;
    ts_model = 1'b0;
    arm_read(REG_STAT, r); check("rst_mid_stat", r, 32'h0);

    // INIT in the middle of a bus cycle keeps the transfer registers.
    arm_write(REG_ADDR, 32'(18'o6000));
    arm_write(REG_CSR, {16'd3, 12'h0, 1'b0, 1'b1, 1'b0, 1'b1});
    wait_msyn(200);
    ubus.init_in_h = 1'b1;
    @(negedge CLOCK);
    bus_zero("init_mid");
    ubus.init_in_h = 1'b0;
    arm_read(REG_CSR, r);  check("init_csr", r, {16'd3, 12'h0, 1'b0, 1'b1, 1'b0, 1'b1});
    arm_read(REG_ADDR, r); check("init_addr", r, 32'(18'o6000));
    arm_read(REG_STAT, r); check("init_stat", r, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
